// File: rtl/prime_pkg.sv
// prime_pkg: shared widths and the FIFO entry type for the prime gap logger.
// Build option TWIN_DETECT_EN adds a twin bit to every stored entry.
package prime_pkg;

  localparam int NUM_W_DEF = 10;
  localparam int CNT_W_DEF = 8;
  localparam int TWIN_GAP  = 2;

  typedef struct packed {
    logic [NUM_W_DEF-1:0] value;
    logic [NUM_W_DEF-1:0] gap;
`ifdef TWIN_DETECT_EN
    logic                 twin;
`endif
  } prime_entry_t;

endpackage

// File: rtl/prime_sync_fifo.sv
// prime_sync_fifo: generic synchronous FIFO with push/pop/full/empty.
// Storage is cleared on reset so the head reads 0 while empty.
module prime_sync_fifo
  import prime_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = prime_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // On a full FIFO the write slot is the head being popped this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/prime_gap_fifo.sv
// prime_gap_fifo: logs new primes with gap/twin tags into a FIFO.
// Build option TWIN_DETECT_EN enables per-entry twin flags.
module prime_gap_fifo
  import prime_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             Prime,
  input  logic [NUM_W-1:0] NumberChecked,
  input  logic             OutReady,
  output logic             OutValid,
  output logic [NUM_W-1:0] OutPrime,
  output logic [NUM_W-1:0] OutGap,
  output logic             OutTwin,
  output logic             Full,
  output logic [CNT_W-1:0] PrimesLogged,
  output logic [CNT_W-1:0] Dropped
);

  typedef struct packed {
    logic [NUM_W-1:0] value;
    logic [NUM_W-1:0] gap;
`ifdef TWIN_DETECT_EN
    logic             twin;
`endif
  } entry_t;

  logic [NUM_W-1:0] last;
  logic [NUM_W-1:0] prev;
  logic             have_prev;
  logic [CNT_W-1:0] logged;
  logic [CNT_W-1:0] dropped;

  logic             capture;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [NUM_W-1:0] gap;
  entry_t           din;
  entry_t           dout;

  assign capture = Prime && (!have_prev || NumberChecked != last);
  assign gap     = have_prev ? NumberChecked - prev : '0;
  assign pop     = !empty && OutReady;
  assign push    = capture && (!full || pop);

  always_comb begin
    din       = '0;
    din.value = NumberChecked;
    din.gap   = gap;
`ifdef TWIN_DETECT_EN
    din.twin  = (gap == NUM_W'(TWIN_GAP));
`endif
  end

  // prev advances even on a drop so the next gap spans the lost prime
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      last      <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      logged    <= '0;
      dropped   <= '0;
    end else if (capture) begin
      last      <= NumberChecked;
      prev      <= NumberChecked;
      have_prev <= 1'b1;
      if (logged != '1)
        logged <= logged + CNT_W'(1);
      if (!push && dropped != '1)
        dropped <= dropped + CNT_W'(1);
    end
  end

  prime_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (SysClk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign OutValid     = !empty;
  assign Full         = full;
  assign OutPrime     = dout.value;
  assign OutGap       = dout.gap;
`ifdef TWIN_DETECT_EN
  assign OutTwin      = dout.twin;
`else
  assign OutTwin      = 1'b0;
`endif
  assign PrimesLogged = logged;
  assign Dropped      = dropped;

endmodule

// File: tb/tb_prime_gap_fifo.sv
// tb_prime_gap_fifo: scoreboard bench for prime_gap_fifo (DEPTH=4).
// Twin expectations follow the TWIN_DETECT_EN build option.
module tb_prime_gap_fifo;

  localparam int DEPTH = 4;
`ifdef TWIN_DETECT_EN
  localparam bit TW = 1'b1;
`else
  localparam bit TW = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] v;
    logic [9:0] g;
    logic       t;
  } ent_t;

  logic       clk = 0;
  logic       Reset = 1;
  logic       Prime = 0;
  logic [9:0] NumberChecked = 0;
  logic       OutReady = 0;
  logic       OutValid;
  logic [9:0] OutPrime;
  logic [9:0] OutGap;
  logic       OutTwin;
  logic       Full;
  logic [7:0] PrimesLogged;
  logic [7:0] Dropped;

  int checks = 0;
  int failures = 0;
  bit en = 0;

  ent_t q[$];
  ent_t seen[$];
  int   m_cnt, m_log, m_drop;
  bit   m_hp;
  logic [9:0] m_last, m_prev;

  prime_gap_fifo #(.NUM_W(10), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .SysClk        (clk),
    .Reset         (Reset),
    .Prime         (Prime),
    .NumberChecked (NumberChecked),
    .OutReady      (OutReady),
    .OutValid      (OutValid),
    .OutPrime      (OutPrime),
    .OutGap        (OutGap),
    .OutTwin       (OutTwin),
    .Full          (Full),
    .PrimesLogged  (PrimesLogged),
    .Dropped       (Dropped)
  );

  initial forever #5 clk = ~clk;

  function automatic ent_t mk(int v, int g, bit t);
    ent_t e;
    e.v = 10'(v);
    e.g = 10'(g);
    e.t = t;
    return e;
  endfunction

  // Reference model: expected entries queued as stimulus is applied
  always @(posedge clk) begin
    bit pop, cap, push;
    logic [9:0] g;
    if (Reset) begin
      m_cnt = 0; m_hp = 0; m_last = 0; m_prev = 0;
      m_log = 0; m_drop = 0;
      q.delete();
    end else begin
      pop  = OutReady && m_cnt > 0;
      cap  = Prime && (!m_hp || NumberChecked != m_last);
      push = cap && (m_cnt < DEPTH || pop);
      g    = m_hp ? NumberChecked - m_prev : 10'd0;
      if (pop) begin
        void'(q.pop_front());
        m_cnt--;
      end
      if (cap) begin
        m_hp = 1; m_last = NumberChecked; m_prev = NumberChecked;
        if (m_log < 255) m_log++;
        if (!push && m_drop < 255) m_drop++;
      end
      if (push) begin
        q.push_back(mk(NumberChecked, g, TW && g == 10'd2));
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      checks++;
      if (OutValid !== (m_cnt != 0)) begin
        failures++;
        $display("FAIL valid: got %b want %b", OutValid, m_cnt != 0);
      end
      checks++;
      if (Full !== (m_cnt == DEPTH)) begin
        failures++;
        $display("FAIL full: got %b want %b", Full, m_cnt == DEPTH);
      end
      checks++;
      if (PrimesLogged !== 8'(m_log) || Dropped !== 8'(m_drop)) begin
        failures++;
        $display("FAIL counters: got %0d/%0d want %0d/%0d",
                 PrimesLogged, Dropped, m_log, m_drop);
      end
      if (OutValid === 1'b1 && q.size() > 0) begin
        checks++;
        if ({OutPrime, OutGap, OutTwin} !== q[0]) begin
          failures++;
          $display("FAIL head: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   OutPrime, OutGap, OutTwin, q[0].v, q[0].g, q[0].t);
        end
        if (OutReady) seen.push_back(mk(OutPrime, OutGap, OutTwin));
      end
    end
  end

  task automatic step(bit p, int n, bit r);
    Prime = p;
    NumberChecked = 10'(n);
    OutReady = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1;
    step(0, 0, 0);
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    Reset = 0;
    checks++;
    if (OutValid !== 0 || Full !== 0 || PrimesLogged !== 0 || Dropped !== 0) begin
      failures++;
      $display("FAIL reset: got v=%b f=%b pl=%0d d=%0d want 0 0 0 0",
               OutValid, Full, PrimesLogged, Dropped);
    end
    en = 1;
  endtask

  task automatic test_stream();
    ent_t e[$];
    seen.delete();
    for (int n = 2; n <= 7; n++)
      for (int k = 0; k < 4; k++)
        step(n == 2 || n == 3 || n == 5 || n == 7, n, 1);
    repeat (3) step(0, 7, 1);
    e.push_back(mk(2, 0, 0));
    e.push_back(mk(3, 1, 0));
    e.push_back(mk(5, 2, TW));
    e.push_back(mk(7, 2, TW));
    checks++;
    if (seen.size() != e.size()) begin
      failures++;
      $display("FAIL stream_count: got %0d want %0d", seen.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== e[i]) begin
        failures++;
        $display("FAIL stream_entry%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 i, seen[i].v, seen[i].g, seen[i].t, e[i].v, e[i].g, e[i].t);
      end
    end
    checks++;
    if (PrimesLogged !== 8'd4) begin
      failures++;
      $display("FAIL stream_logged: got %0d want 4", PrimesLogged);
    end
  endtask

  task automatic test_dedup();
    seen.delete();
    repeat (6) step(1, 11, 1);
    repeat (3) step(0, 11, 1);
    checks++;
    if (seen.size() != 1 || seen[0] !== mk(11, 4, 0)) begin
      failures++;
      $display("FAIL dedup: got n=%0d first=(%0d,%0d) want n=1 (11,4)",
               seen.size(), seen.size() ? seen[0].v : 0,
               seen.size() ? seen[0].g : 0);
    end
  endtask

  task automatic test_overflow();
    int p[6] = '{2, 3, 5, 7, 11, 13};
    ent_t e[$];
    do_reset();
    seen.delete();
    foreach (p[i]) step(1, p[i], 0);
    step(0, 13, 0);
    checks++;
    if (Full !== 1 || Dropped !== 8'd2 || PrimesLogged !== 8'd6) begin
      failures++;
      $display("FAIL overflow: got f=%b d=%0d pl=%0d want 1 2 6",
               Full, Dropped, PrimesLogged);
    end
    repeat (6) step(0, 13, 1);
    step(1, 17, 1);
    repeat (3) step(0, 17, 1);
    e.push_back(mk(2, 0, 0));
    e.push_back(mk(3, 1, 0));
    e.push_back(mk(5, 2, TW));
    e.push_back(mk(7, 2, TW));
    e.push_back(mk(17, 4, 0));
    checks++;
    if (seen.size() != e.size()) begin
      failures++;
      $display("FAIL overflow_count: got %0d want %0d", seen.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== e[i]) begin
        failures++;
        $display("FAIL overflow_entry%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 i, seen[i].v, seen[i].g, seen[i].t, e[i].v, e[i].g, e[i].t);
      end
    end
  endtask

  task automatic test_full_push_pop();
    int p[4] = '{19, 23, 29, 31};
    ent_t e[$];
    seen.delete();
    foreach (p[i]) step(1, p[i], 0);
    step(1, 37, 1);
    Prime = 0;
    OutReady = 0;
    checks++;
    if (Full !== 1 || Dropped !== 8'd2) begin
      failures++;
      $display("FAIL full_push_pop: got f=%b d=%0d want 1 2", Full, Dropped);
    end
    repeat (6) step(0, 37, 1);
    e.push_back(mk(19, 2, TW));
    e.push_back(mk(23, 4, 0));
    e.push_back(mk(29, 6, 0));
    e.push_back(mk(31, 2, TW));
    e.push_back(mk(37, 6, 0));
    checks++;
    if (seen.size() != e.size()) begin
      failures++;
      $display("FAIL pushpop_count: got %0d want %0d", seen.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== e[i]) begin
        failures++;
        $display("FAIL pushpop_entry%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 i, seen[i].v, seen[i].g, seen[i].t, e[i].v, e[i].g, e[i].t);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 41, 0);
    step(1, 43, 0);
    step(1, 47, 0);
    step(0, 47, 0);
    checks++;
    if (OutValid !== 1) begin
      failures++;
      $display("FAIL mid_buffered: got valid=%b want 1", OutValid);
    end
    Reset = 1;
    step(0, 47, 0);
    Reset = 0;
    checks++;
    if (OutValid !== 0) begin
      failures++;
      $display("FAIL mid_reset_valid: got %b want 0", OutValid);
    end
    seen.delete();
    step(1, 23, 0);
    repeat (3) step(0, 23, 1);
    checks++;
    if (seen.size() != 1 || seen[0] !== mk(23, 0, 0) || PrimesLogged !== 8'd1) begin
      failures++;
      $display("FAIL mid_reset_first: got n=%0d pl=%0d want n=1 (23,0,0) pl=1",
               seen.size(), PrimesLogged);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_dedup();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
